// File: rtl/regfile_seq_pkg.sv
// Shared op-codes, FSM state encoding and default widths for the register-file sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_seq_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_READ = 2'b01,
    OP_MOVE = 2'b10,
    OP_SWAP = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    WR1  = 3'd3,
    WR2  = 3'd4
  } state_t;

endpackage

// File: rtl/regfile_seq_if.sv
// Command/response handshake plus register-file bus shared by host, sequencer and register file.
// Latency: none (wires only).
// Backpressure: cmdReady from the sequencer gates command acceptance.
interface regfile_seq_if #(
  parameter int DATA_W = regfile_seq_pkg::DEF_DATA_W,
  parameter int ADDR_W = regfile_seq_pkg::DEF_ADDR_W
) ();

  logic              cmdValid;
  logic              cmdReady;
  logic [1:0]        cmdOp;
  logic [ADDR_W-1:0] cmdA;
  logic [ADDR_W-1:0] cmdB;
  logic [DATA_W-1:0] cmdImm;
  logic              rspValid;
  logic [DATA_W-1:0] rspData;
  logic              busy;

  logic [ADDR_W-1:0] addrBus;
  logic [DATA_W-1:0] inBus;
  logic              readMem;
  logic              writeMem;
  logic [DATA_W-1:0] outBus;

  // Host side: issues commands, observes responses.
  modport master (
    output cmdValid, cmdOp, cmdA, cmdB, cmdImm,
    input  cmdReady, rspValid, rspData, busy
  );

  // Sequencer side: accepts commands and drives the register-file bus.
  modport slave (
    input  cmdValid, cmdOp, cmdA, cmdB, cmdImm, outBus,
    output cmdReady, rspValid, rspData, busy,
    output addrBus, inBus, readMem, writeMem
  );

  // Register-file side of the bus.
  modport rf (
    input  addrBus, inBus, readMem, writeMem,
    output outBus
  );

endinterface

// File: rtl/regfile_seq_rf.sv
// Small register file driven by the sequencer bus: write on posedge, combinational read.
// Latency: write visible the cycle after writeMem; read data same cycle as readMem.
// Backpressure: none, always ready.
module regfile_seq_rf #(
  parameter int DATA_W = regfile_seq_pkg::DEF_DATA_W,
  parameter int ADDR_W = regfile_seq_pkg::DEF_ADDR_W
) (
  input logic     clk,
  regfile_seq_if.rf rfPort
);

  logic [DATA_W-1:0] regs [2**ADDR_W];

  // Storage write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (rfPort.writeMem) begin
      regs[rfPort.addrBus] <= rfPort.inBus;
    end
  end

  assign rfPort.outBus = rfPort.readMem ? regs[rfPort.addrBus] : '0;

endmodule

// File: rtl/regfile_seq.sv
// Sequencer turning LOAD/READ/MOVE/SWAP commands into register-file read/write cycles.
// Latency: accept-to-idle LOAD 1, READ 1 (+1 cycle rspValid), MOVE 2, SWAP 4 cycles.
// Backpressure: cmdReady high only in IDLE; commands offered while busy are dropped.
module regfile_seq
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic        clk,
  input logic        rst,
  regfile_seq_if.slave sq
);

  state_t            state;
  op_t               opQ;
  logic [ADDR_W-1:0] aQ;
  logic [ADDR_W-1:0] bQ;
  logic [DATA_W-1:0] immQ;
  logic [DATA_W-1:0] tA;
  logic [DATA_W-1:0] tB;
  logic              rspValidQ;
  logic [DATA_W-1:0] rspDataQ;

  logic [ADDR_W-1:0] addrBus;
  logic [DATA_W-1:0] inBus;
  logic              readMem;
  logic              writeReq;

  // Sequencing FSM: latches the command in IDLE and walks the read/write phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      opQ       <= OP_LOAD;
      aQ        <= '0;
      bQ        <= '0;
      immQ      <= '0;
      tA        <= '0;
      tB        <= '0;
      rspValidQ <= 1'b0;
      rspDataQ  <= '0;
    end else begin
      rspValidQ <= 1'b0;
      case (state)
        IDLE: begin
          if (sq.cmdValid) begin
            opQ   <= op_t'(sq.cmdOp);
            aQ    <= sq.cmdA;
            bQ    <= sq.cmdB;
            immQ  <= sq.cmdImm;
            state <= (op_t'(sq.cmdOp) == OP_LOAD) ? WR1 : RD1;
          end
        end
        RD1: begin
          case (opQ)
            OP_READ: begin
              rspDataQ  <= sq.outBus;
              rspValidQ <= 1'b1;
              state     <= IDLE;
            end
            OP_MOVE: begin
              tA    <= sq.outBus;
              state <= WR1;
            end
            default: begin
              tA    <= sq.outBus;
              state <= RD2;
            end
          endcase
        end
        RD2: begin
          tB    <= sq.outBus;
          state <= WR1;
        end
        WR1:     state <= (opQ == OP_SWAP) ? WR2 : IDLE;
        WR2:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus decode from registered state and latches only, so cmd* never reaches the bus combinationally.
  always_comb begin
    addrBus  = '0;
    inBus    = '0;
    readMem  = 1'b0;
    writeReq = 1'b0;
    case (state)
      RD1: begin
        addrBus = (opQ == OP_MOVE) ? bQ : aQ;
        readMem = 1'b1;
      end
      RD2: begin
        addrBus = bQ;
        readMem = 1'b1;
      end
      WR1: begin
        addrBus  = aQ;
        writeReq = 1'b1;
        case (opQ)
          OP_LOAD: inBus = immQ;
          OP_SWAP: inBus = tB;
          default: inBus = tA;
        endcase
      end
      WR2: begin
        addrBus  = bQ;
        inBus    = tA;
        writeReq = 1'b1;
      end
      default: ;
    endcase
  end

  // rst suppresses the write on the reset edge itself so an aborted SWAP leaves the file untouched.
  assign sq.writeMem = writeReq & ~rst;
  assign sq.readMem  = readMem;
  assign sq.addrBus  = addrBus;
  assign sq.inBus    = inBus;
  assign sq.cmdReady = (state == IDLE);
  assign sq.busy     = (state != IDLE);
  assign sq.rspValid = rspValidQ;
  assign sq.rspData  = rspDataQ;

endmodule

// File: tb/tb_regfile_seq.sv
// Bench: sequencer plus register file, random commands checked against an array model.
// Latency: checks accept-to-idle cycle counts and response timing.
// Backpressure: offers commands while busy and holds cmdValid for back-to-back READs.
module tb_regfile_seq;
  import regfile_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_seq_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  regfile_seq #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .sq  (bus.slave)
  );

  regfile_seq_rf #(.DATA_W(16), .ADDR_W(3)) rf (
    .clk    (clk),
    .rfPort (bus.rf)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  logic [15:0] refMem [8];
  logic [15:0] lastRead = 16'h0;
  int          writeCnt = 0;
  int          rspCnt   = 0;
  int          rwBoth   = 0;
  int          idleBusErr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Mid-low-phase monitor: counts writes and responses, flags bus rule violations.
  always @(negedge clk) begin
    #2;
    if (bus.writeMem === 1'b1) writeCnt++;
    if (bus.rspValid === 1'b1) rspCnt++;
    if (bus.readMem === 1'b1 && bus.writeMem === 1'b1) rwBoth++;
    if (bus.busy === 1'b0 && (bus.readMem !== 1'b0 || bus.writeMem !== 1'b0 ||
                              bus.addrBus !== 3'd0 || bus.inBus !== 16'd0)) idleBusErr++;
    assert (!(bus.readMem === 1'b1 && bus.writeMem === 1'b1))
      else $error("FAIL rw_exclusive: readMem and writeMem both 1");
  end

  task automatic applyModel(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                            input logic [15:0] imm);
    logic [15:0] t;
    case (op)
      2'b00: refMem[a] = imm;
      2'b10: refMem[a] = refMem[b];
      2'b11: begin t = refMem[a]; refMem[a] = refMem[b]; refMem[b] = t; end
      default: ;
    endcase
  endtask

  task automatic doCmd(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic [15:0] imm, input bit noise);
    int w0, r0, cyc, expLat, expWr;
    logic [15:0] expRd;
    case (op)
      2'b00: begin expLat = 1; expWr = 1; end
      2'b01: begin expLat = 1; expWr = 0; end
      2'b10: begin expLat = 2; expWr = 1; end
      default: begin expLat = 4; expWr = 2; end
    endcase
    @(negedge clk);
    chk("ready_in_idle", 32'(bus.cmdReady), 1);
    bus.cmdValid = 1'b1;
    bus.cmdOp    = op;
    bus.cmdA     = a;
    bus.cmdB     = b;
    bus.cmdImm   = imm;
    w0 = writeCnt;
    r0 = rspCnt;
    expRd = refMem[a];
    applyModel(op, a, b, imm);
    @(posedge clk);
    #1;
    bus.cmdValid = 1'b0;
    bus.cmdImm   = 16'($urandom);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (bus.busy !== 1'b1 || cyc > 20) break;
      cyc++;
      if (noise) begin
        bus.cmdValid = 1'b1;
        bus.cmdOp    = 2'($urandom);
        bus.cmdA     = 3'($urandom);
        bus.cmdB     = 3'($urandom);
        bus.cmdImm   = 16'($urandom);
      end
    end
    bus.cmdValid = 1'b0;
    #3;
    chk("busy_cycles", 32'(cyc), 32'(expLat));
    chk("write_count", 32'(writeCnt - w0), 32'(expWr));
    chk("rsp_count", 32'(rspCnt - r0), (op == 2'b01) ? 1 : 0);
    chk("rsp_valid_at_idle", 32'(bus.rspValid), (op == 2'b01) ? 1 : 0);
    if (op == 2'b01) lastRead = expRd;
    chk("rsp_data", 32'(bus.rspData), 32'(lastRead));
  endtask

  initial begin
    logic [2:0] a;
    int acc;
    logic [15:0] q [$];

    bus.cmdValid = 1'b1;
    bus.cmdOp    = 2'b00;
    bus.cmdA     = 3'd7;
    bus.cmdB     = 3'd0;
    bus.cmdImm   = 16'hDEAD;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.cmdValid = 1'b0;
    #1;
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_ready", 32'(bus.cmdReady), 1);
    chk("reset_rspValid", 32'(bus.rspValid), 0);
    chk("reset_rspData", 32'(bus.rspData), 0);
    chk("reset_readMem", 32'(bus.readMem), 0);
    chk("reset_writeMem", 32'(bus.writeMem), 0);
    chk("reset_addrBus", 32'(bus.addrBus), 0);
    chk("reset_inBus", 32'(bus.inBus), 0);

    for (int r = 0; r < 8; r++) doCmd(2'b00, 3'(r), 3'($urandom), 16'($urandom), 1'b0);

    doCmd(2'b00, 3'd3, 3'd0, 16'hBEEF, 1'b0);
    doCmd(2'b01, 3'd3, 3'd0, 16'h0, 1'b0);
    chk("beef_read", 32'(bus.rspData), 32'h0000BEEF);

    doCmd(2'b00, 3'd1, 3'd0, 16'h0011, 1'b0);
    doCmd(2'b00, 3'd2, 3'd0, 16'h0022, 1'b0);
    doCmd(2'b10, 3'd5, 3'd2, 16'h0, 1'b0);
    doCmd(2'b01, 3'd5, 3'd0, 16'h0, 1'b0);
    chk("move_dst", 32'(bus.rspData), 32'h00000022);
    doCmd(2'b01, 3'd2, 3'd0, 16'h0, 1'b0);
    chk("move_src_kept", 32'(bus.rspData), 32'h00000022);

    doCmd(2'b11, 3'd1, 3'd2, 16'h0, 1'b0);
    doCmd(2'b01, 3'd1, 3'd0, 16'h0, 1'b0);
    chk("swap_r1", 32'(bus.rspData), 32'h00000022);
    doCmd(2'b01, 3'd2, 3'd0, 16'h0, 1'b0);
    chk("swap_r2", 32'(bus.rspData), 32'h00000011);

    doCmd(2'b00, 3'd4, 3'd0, 16'h1234, 1'b0);
    doCmd(2'b11, 3'd4, 3'd4, 16'h0, 1'b1);
    doCmd(2'b01, 3'd4, 3'd0, 16'h0, 1'b0);
    chk("swap_same_reg", 32'(bus.rspData), 32'h00001234);
    doCmd(2'b10, 3'd6, 3'd6, 16'h0, 1'b1);

    // Abort a SWAP in WR1.
    doCmd(2'b00, 3'd1, 3'd0, 16'hAAAA, 1'b0);
    doCmd(2'b00, 3'd2, 3'd0, 16'h5555, 1'b0);
    @(negedge clk);
    bus.cmdValid = 1'b1;
    bus.cmdOp    = 2'b11;
    bus.cmdA     = 3'd1;
    bus.cmdB     = 3'd2;
    acc = writeCnt;
    @(posedge clk);
    #1;
    bus.cmdValid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_in_wr1_addr", 32'(bus.addrBus), 1);
    rst = 1'b1;
    #1;
    chk("abort_write_gated", 32'(bus.writeMem), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_ready", 32'(bus.cmdReady), 1);
    chk("abort_rspValid", 32'(bus.rspValid), 0);
    chk("abort_rspData", 32'(bus.rspData), 0);
    chk("abort_readMem", 32'(bus.readMem), 0);
    chk("abort_writeMem", 32'(bus.writeMem), 0);
    chk("abort_addrBus", 32'(bus.addrBus), 0);
    chk("abort_inBus", 32'(bus.inBus), 0);
    repeat (3) @(negedge clk);
    #3;
    chk("abort_no_writes", 32'(writeCnt - acc), 0);
    lastRead = 16'h0;
    doCmd(2'b01, 3'd1, 3'd0, 16'h0, 1'b0);
    chk("abort_r1", 32'(bus.rspData), 32'h0000AAAA);
    doCmd(2'b01, 3'd2, 3'd0, 16'h0, 1'b0);
    chk("abort_r2", 32'(bus.rspData), 32'h00005555);

    for (int i = 0; i < 40; i++) begin
      doCmd(2'($urandom), 3'($urandom), 3'($urandom), 16'($urandom), 1'($urandom));
    end

    // Back-to-back READs with cmdValid held high.
    @(negedge clk);
    bus.cmdValid = 1'b1;
    bus.cmdOp    = 2'b01;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.rspValid === 1'b1) begin
        if (q.size() == 0) chk("b2b_extra_rsp", 1, 0);
        else begin
          lastRead = q.pop_front();
          chk("b2b_data", 32'(bus.rspData), 32'(lastRead));
        end
      end
      if (bus.cmdReady === 1'b1) begin
        a = 3'($urandom);
        bus.cmdA = a;
        bus.cmdB = 3'($urandom);
        q.push_back(refMem[a]);
        acc++;
      end
    end
    bus.cmdValid = 1'b0;
    @(negedge clk);
    chk("b2b_last_rsp_valid", 32'(bus.rspValid), 1);
    if (q.size() != 0) begin
      lastRead = q.pop_front();
      chk("b2b_last_data", 32'(bus.rspData), 32'(lastRead));
    end
    chk("b2b_accepts", 32'(acc), 6);
    chk("b2b_queue_empty", 32'(q.size()), 0);

    repeat (2) @(negedge clk);
    chk("rw_never_both", 32'(rwBoth), 0);
    chk("idle_bus_zero", 32'(idleBusErr), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
